// File: rtl/init_table_pkg.sv
// Shared types and helpers for the initialised-table streamer: state encoding,
// index widths, table reset contents and the per-element affine result.
package init_table_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  // Index width for a dimension of n entries; a 1-entry dimension still gets a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] elem_init(input int r, input int c, input int cols);
    return 32'(r * cols + c);
  endfunction

  // a - kb*b - temp*t + kz*zinit, with each product truncated to nx bits
  // before the modular sum.
  function automatic logic [31:0] affine(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] t, input int temp,
                                         input int kb, input int kz, input int zinit,
                                         input int nx);
    logic [31:0] mask, pb, pt, pz;
    mask = (nx >= 32) ? '1 : ((32'd1 << nx) - 32'd1);
    pb   = (32'(kb) * b) & mask;
    pt   = (32'(temp) * t) & mask;
    pz   = (32'(kz) * 32'(zinit)) & mask;
    return (a - pb - pt + pz) & mask;
  endfunction

endpackage

// File: rtl/init_table_mem.sv
// ROWS x COLS register table: resets to row-major index values, one write
// port committing at the edge, one combinational read port.
module init_table_mem
  import init_table_pkg::*;
#(
  parameter int NX   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int RW  = idx_w(ROWS),
  localparam int CW  = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [NX-1:0] wr_data,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [NX-1:0] rd_data
);

  logic [ROWS-1:0][COLS-1:0][NX-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_row][wr_col] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem_q[r][c] <= NX'(elem_init(r, c, COLS));
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_row][rd_col];

endmodule

// File: rtl/init_table_streamer.sv
// Sequential, back-pressured scan of the initialised table: on START every
// entry is read in row-major order and one affine result per entry is streamed.
module init_table_streamer
  import init_table_pkg::*;
#(
  parameter int NX    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int TEMP  = 21,
  parameter int KB    = 3,
  parameter int KZ    = 11,
  parameter int ZINIT = 1,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [NX-1:0] A,
  input  logic [NX-1:0] B,
  input  logic          START,
  input  logic          WR_EN,
  input  logic [RW-1:0] WR_ROW,
  input  logic [CW-1:0] WR_COL,
  input  logic [NX-1:0] WR_DATA,
  output logic          BUSY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [NX-1:0] OUT_DATA,
  output logic [RW-1:0] OUT_ROW,
  output logic [CW-1:0] OUT_COL,
  output logic          OUT_LAST,
  output logic          DONE
);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d, nxt_row, rd_row;
  logic [CW-1:0] col_q, col_d, nxt_col, rd_col;
  logic [NX-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [NX-1:0] mem_rd, rd_val, op_a, op_b, result;
  logic          wr_acc, col_wrap, last, run;

  assign run      = (state_q == RUN);
  assign wr_acc   = WR_EN && !run;
  assign col_wrap = (col_q == CW'(COLS - 1));
  assign last     = col_wrap && (row_q == RW'(ROWS - 1));
  assign nxt_col  = col_wrap ? '0 : col_q + CW'(1);
  assign nxt_row  = col_wrap ? row_q + RW'(1) : row_q;

  // In IDLE the lookahead read targets (0,0); a write landing on the same
  // edge as START is forwarded so the first beat sees the new value.
  assign rd_row = run ? nxt_row : '0;
  assign rd_col = run ? nxt_col : '0;
  assign rd_val = (wr_acc && WR_ROW == rd_row && WR_COL == rd_col) ? WR_DATA : mem_rd;
  assign op_a   = run ? a_q : A;
  assign op_b   = run ? b_q : B;
  assign result = NX'(affine(32'(op_a), 32'(op_b), 32'(rd_val), TEMP, KB, KZ, ZINIT, NX));

  init_table_mem #(.NX(NX), .ROWS(ROWS), .COLS(COLS)) u_mem (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (wr_acc),
    .wr_row  (WR_ROW),
    .wr_col  (WR_COL),
    .wr_data (WR_DATA),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (mem_rd)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = RUN;
        a_d     = A;
        b_d     = B;
        row_d   = '0;
        col_d   = '0;
        data_d  = result;
      end
      RUN: if (OUT_READY) begin
        if (last) begin
          state_d = FINISH;
        end else begin
          row_d  = nxt_row;
          col_d  = nxt_col;
          data_d = result;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign BUSY      = run;
  assign OUT_VALID = run;
  assign OUT_LAST  = run && last;
  assign DONE      = (state_q == FINISH);
  assign OUT_DATA  = data_q;
  assign OUT_ROW   = row_q;
  assign OUT_COL   = col_q;

endmodule

// File: tb/tb_init_table_streamer.sv
// Randomised self-checking bench for init_table_streamer against a flat
// array model of the table and the affine rule in plain integer arithmetic.
module tb_init_table_streamer;

  localparam int NX = 8, ROWS = 4, COLS = 4, N = ROWS * COLS;
  localparam int TEMP = 21, KB = 3, KZ = 11, ZINIT = 1;

  logic       CLK = 0, RST_N = 0, START = 0, WR_EN = 0, OUT_READY = 0;
  logic [7:0] A = 0, B = 0, WR_DATA = 0;
  logic [1:0] WR_ROW = 0, WR_COL = 0;
  logic       BUSY, OUT_VALID, OUT_LAST, DONE;
  logic [7:0] OUT_DATA;
  logic [1:0] OUT_ROW, OUT_COL;

  init_table_streamer #(.NX(NX), .ROWS(ROWS), .COLS(COLS), .TEMP(TEMP), .KB(KB),
                        .KZ(KZ), .ZINIT(ZINIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .START(START), .WR_EN(WR_EN),
    .WR_ROW(WR_ROW), .WR_COL(WR_COL), .WR_DATA(WR_DATA), .BUSY(BUSY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  int tbl[N];
  int got_d[32], got_r[32], got_c[32], got_l[32];
  int n_beats, done_cyc, last_cyc, stall_err, timeout, n_hold;
  int hold_d[3], hold_rc[3];
  logic first_valid;
  logic [2:0] post_st;

  function automatic int exp_out(input int a, input int b, input int t);
    return (a - KB * b - TEMP * t + KZ * ZINIT) & 255;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) tbl[k] = k & 255;
  endtask

  task automatic wr(input int r, input int c, input int d);
    WR_EN = 1; WR_ROW = r[1:0]; WR_COL = c[1:0]; WR_DATA = d[7:0];
    @(posedge CLK); #1;
    WR_EN = 0;
    tbl[r * COLS + c] = d & 255;
  endtask

  // Runs one scan starting in IDLE and records every transferred beat.
  task automatic do_scan(input int a, input int b, input int rdy_pct, input bit poke,
                         input int stall_idx, input bit wr_start, input int wr_r,
                         input int wr_c, input int wr_d);
    int cyc, stalls;
    bit rdy, pv, pr;
    logic [12:0] prev;
    n_beats = 0; done_cyc = -1; last_cyc = -1; stall_err = 0; timeout = 0;
    n_hold = 0; stalls = 0; pv = 0; pr = 0; prev = '0;
    A = a[7:0]; B = b[7:0]; START = 1;
    if (wr_start) begin
      WR_EN = 1; WR_ROW = wr_r[1:0]; WR_COL = wr_c[1:0]; WR_DATA = wr_d[7:0];
      tbl[wr_r * COLS + wr_c] = wr_d & 255;
    end
    @(posedge CLK); #1;
    START = 0; WR_EN = 0;
    first_valid = OUT_VALID;
    cyc = 0;
    while (done_cyc < 0) begin
      if (cyc > 300) begin timeout = 1; break; end
      if (pv && !pr && {OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST} !== {1'b1, prev}) stall_err++;
      if (DONE) begin done_cyc = cyc; break; end
      rdy = ($urandom_range(99) < rdy_pct);
      if (OUT_VALID && int'(OUT_ROW) * COLS + int'(OUT_COL) == stall_idx && stalls < 3) begin
        rdy = 0;
        hold_d[n_hold] = OUT_DATA; hold_rc[n_hold] = {OUT_ROW, OUT_COL};
        n_hold++; stalls++;
      end
      OUT_READY = rdy;
      if (OUT_VALID && rdy) begin
        if (n_beats < 32) begin
          got_d[n_beats] = OUT_DATA; got_r[n_beats] = OUT_ROW;
          got_c[n_beats] = OUT_COL;  got_l[n_beats] = OUT_LAST;
        end
        last_cyc = cyc; n_beats++;
      end
      START = poke & OUT_VALID; WR_EN = poke & OUT_VALID;
      WR_ROW = 0; WR_COL = 0; WR_DATA = 99;
      pv = OUT_VALID; pr = rdy; prev = {OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST};
      @(posedge CLK); #1; cyc++;
    end
    OUT_READY = 0; START = 0; WR_EN = 0;
    @(posedge CLK); #1;
    post_st = {DONE, OUT_VALID, BUSY};
  endtask

  task automatic test_reset();
    RST_N = 0; model_reset();
    repeat (2) @(posedge CLK); #1;
    tests++;
    if ({BUSY, OUT_VALID, OUT_LAST, DONE, OUT_DATA, OUT_ROW, OUT_COL} !== 16'h0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {BUSY, OUT_VALID, OUT_LAST, DONE, OUT_DATA, OUT_ROW, OUT_COL});
    end
    RST_N = 1; @(posedge CLK); #1;
  endtask

  task automatic test_basic_scan();
    int k;
    do_scan(100, 10, 100, 0, -1, 0, 0, 0, 0);
    tests++; if (first_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: valid %b expected 1", first_valid); end
    tests++; if (n_beats != N || timeout != 0) begin fails++; $display("FAIL basic_beats: got %0d expected %0d (timeout %0d)", n_beats, N, timeout); end
    tests++; if (done_cyc != last_cyc + 1 || last_cyc != N - 1) begin fails++; $display("FAIL basic_done: done %0d last %0d expected %0d/%0d", done_cyc, last_cyc, N, N - 1); end
    tests++; if (post_st !== 3'b000) begin fails++; $display("FAIL basic_done_pulse: got %b expected 000", post_st); end
    tests++; if (got_d[0] != 81 || got_d[1] != 60 || got_d[6] != 211 || got_d[15] != 22) begin
      fails++; $display("FAIL basic_values: got %0d %0d %0d %0d expected 81 60 211 22", got_d[0], got_d[1], got_d[6], got_d[15]);
    end
    for (k = 0; k < N && k < n_beats; k++) begin
      tests++;
      if (got_d[k] != exp_out(100, 10, tbl[k]) || got_r[k] != k / COLS || got_c[k] != k % COLS || got_l[k] != (k == N - 1)) begin
        fails++; $display("FAIL basic_beat%0d: got d%0d r%0d c%0d l%0d expected d%0d", k, got_d[k], got_r[k], got_c[k], got_l[k], exp_out(100, 10, tbl[k]));
      end
    end
  endtask

  task automatic test_write_idle();
    wr(1, 2, 0);
    do_scan(100, 10, 100, 0, -1, 0, 0, 0, 0);
    tests++; if (n_beats != N || got_d[6] != 81) begin fails++; $display("FAIL write_idle: beats %0d d6 %0d expected %0d 81", n_beats, got_d[6], N); end
    for (int k = 0; k < N && k < n_beats; k++) begin
      tests++;
      if (got_d[k] != exp_out(100, 10, tbl[k]) || got_r[k] != k / COLS || got_c[k] != k % COLS) begin
        fails++; $display("FAIL write_idle_beat%0d: got %0d expected %0d", k, got_d[k], exp_out(100, 10, tbl[k]));
      end
    end
  endtask

  task automatic test_stall();
    do_scan(100, 10, 100, 0, 5, 0, 0, 0, 0);
    tests++; if (n_hold != 3 || stall_err != 0) begin fails++; $display("FAIL stall_hold: holds %0d unstable %0d expected 3 0", n_hold, stall_err); end
    for (int i = 0; i < n_hold; i++) begin
      tests++;
      if (hold_d[i] != 232 || hold_rc[i] != 5) begin
        fails++; $display("FAIL stall_value%0d: got d%0d rc%0d expected d232 rc5", i, hold_d[i], hold_rc[i]);
      end
    end
    tests++; if (n_beats != N) begin fails++; $display("FAIL stall_beats: got %0d expected %0d", n_beats, N); end
    for (int k = 0; k < N && k < n_beats; k++) begin
      tests++;
      if (got_d[k] != exp_out(100, 10, tbl[k]) || got_r[k] * COLS + got_c[k] != k) begin
        fails++; $display("FAIL stall_beat%0d: got %0d expected %0d", k, got_d[k], exp_out(100, 10, tbl[k]));
      end
    end
  endtask

  task automatic test_ignore_in_run();
    do_scan(100, 10, 70, 1, -1, 0, 0, 0, 0);
    tests++; if (n_beats != N || done_cyc < 0) begin fails++; $display("FAIL run_restart: beats %0d done %0d expected %0d", n_beats, done_cyc, N); end
    do_scan(100, 10, 100, 0, -1, 0, 0, 0, 0);
    tests++; if (got_d[0] != 81 || n_beats != N) begin fails++; $display("FAIL run_write_ignored: got %0d expected 81", got_d[0]); end
  endtask

  task automatic test_random();
    int a, b, bad;
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(3)) wr($urandom_range(ROWS - 1), $urandom_range(COLS - 1), $urandom_range(255));
      a = $urandom_range(255); b = $urandom_range(255);
      do_scan(a, b, 20 + $urandom_range(80), 0, -1, 0, 0, 0, 0);
      bad = (n_beats != N || stall_err != 0 || done_cyc != last_cyc + 1) ? 1 : 0;
      for (int k = 0; k < N && k < n_beats; k++)
        if (got_d[k] != exp_out(a, b, tbl[k]) || got_r[k] * COLS + got_c[k] != k || got_l[k] != (k == N - 1)) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL random_scan%0d: %0d bad items (beats %0d) expected 0", s, bad, n_beats); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, dn;
    A = 100; B = 10; START = 1; OUT_READY = 1;
    @(posedge CLK); #1; START = 0;
    cyc = 0;
    while (!(OUT_VALID && OUT_ROW == 1 && OUT_COL == 3) && cyc < 40) begin @(posedge CLK); #1; cyc++; end
    tests++; if (cyc >= 40) begin fails++; $display("FAIL midrst_reach: cycles %0d expected <40", cyc); end
    RST_N = 0; model_reset();
    @(posedge CLK); #1;
    tests++; if ({OUT_VALID, BUSY, DONE} !== 3'b000) begin fails++; $display("FAIL midrst_abort: got %b expected 000", {OUT_VALID, BUSY, DONE}); end
    RST_N = 1; dn = 0;
    repeat (5) begin @(posedge CLK); #1; dn += int'(DONE) + int'(OUT_VALID); end
    OUT_READY = 0;
    tests++; if (dn != 0) begin fails++; $display("FAIL midrst_quiet: got %0d expected 0", dn); end
    do_scan(100, 10, 100, 0, -1, 0, 0, 0, 0);
    for (int k = 0; k < N && k < n_beats; k++) begin
      tests++;
      if (got_d[k] != exp_out(100, 10, k)) begin fails++; $display("FAIL midrst_beat%0d: got %0d expected %0d", k, got_d[k], exp_out(100, 10, k)); end
    end
  endtask

  task automatic test_write_with_start();
    do_scan(0, 0, 100, 0, -1, 1, 2, 0, 255);
    tests++; if (n_beats != N || got_d[8] != 32) begin fails++; $display("FAIL wr_start: beats %0d d8 %0d expected %0d 32", n_beats, got_d[8], N); end
    tests++; if (got_d[8] != exp_out(0, 0, tbl[8]) || got_d[9] != exp_out(0, 0, 9)) begin
      fails++; $display("FAIL wr_start_model: got %0d %0d expected %0d %0d", got_d[8], got_d[9], exp_out(0, 0, tbl[8]), exp_out(0, 0, 9));
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_write_idle();
    test_stall();
    test_ignore_in_run();
    test_random();
    test_reset_mid_scan();
    test_write_with_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
